special_counter_decoder: RTL and testbench
==========================================

Name: special_counter_decoder

Overview:
- Receive-side companion to the ring/Johnson counter generators.
- Samples a ring or Johnson code word and decodes it to a binary sequence index.
- Checks each sample against the expected next code and locks after a run of correct steps.
- Flags illegal or out-of-sequence codes and keeps a saturating error tally; used to check counter-driven sequencers and one-hot/Johnson state buses.

Parameters:
- WIDTH, 4, code width in bits; legal range 2..16.
- MODE, 1, code type: 0 = ring (WIDTH states), 1 = Johnson (2*WIDTH states).
- LOCK_CNT, 2, consecutive correct steps required before locked asserts; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 at posedge resets).
- din_valid  input  1  din is sampled this cycle.
- din  input  WIDTH  code word under test.
- idx  output  $clog2(2*WIDTH)  decoded index of the last legal sample.
- idx_valid  output  1  one-cycle pulse: idx updated from a legal sample.
- locked  output  1  sequence tracked; high for LOCK_CNT or more consecutive correct steps.
- err  output  1  one-cycle pulse: illegal code, or wrong step while locked.
- wrap  output  1  one-cycle pulse: locked step from index N-1 to 0.
- err_cnt  output  8  saturating error count.

Behaviour:
- N = WIDTH (ring) or 2*WIDTH (Johnson). All outputs are registered, with 1-cycle latency from the sampling edge.
- Generator step rules:
  - Ring: next = {din[0], din[WIDTH-1:1]}. Index 0 = 0..01; index k has bit (WIDTH-k) mod WIDTH set.
  - Johnson: next = {~din[0], din[WIDTH-1:1]}. Index 0 = all zeros.
  - Johnson index k (1..WIDTH): top k bits are ones, the rest zeros.
  - Johnson index WIDTH+k (1..WIDTH-1): top k bits are zeros, the rest ones.
- Legality: ring legal iff exactly one bit is set. Johnson legal iff din matches one of the 2*WIDTH codes. Anything else is illegal.
- Reset: state=HUNT, match=0, idx=0, idx_valid=0, locked=0, err=0, wrap=0, err_cnt=0. Reset overrides din_valid and takes effect mid-operation on the next edge.
- din_valid=0: state, idx, match, locked and err_cnt hold; idx_valid, err and wrap are 0.
- Illegal sample (any state): err=1, err_cnt+1 (saturates at 255), state->HUNT, match=0, locked=0, idx holds, idx_valid=0.
- HUNT, legal sample: idx=decoded, idx_valid=1, state->CONFIRM, match=0, no err.
- CONFIRM, legal sample:
  - idx_new == (idx+1) mod N: match+1. When match reaches LOCK_CNT, state->LOCKED and locked=1 in the same output cycle.
  - Otherwise: idx=new, match=0, stay CONFIRM, no err.
- LOCKED, legal sample:
  - Correct step: idx advances, idx_valid=1. wrap=1 when idx goes N-1 to 0.
  - Repeated or skipped code: err=1, err_cnt+1, idx=new, idx_valid=1, locked=0, state->CONFIRM, match=0.
- Simultaneous events: err and wrap are mutually exclusive. Saturated err_cnt stays 255 and err still pulses.
- wrap never pulses outside LOCKED.

Test Plan:
- Johnson, WIDTH=4, LOCK_CNT=2:
  - Reset, then din 0000,1000,1100 -> idx 0,1,2; locked=1 on the output for 1100; err=0.
  - Continue 1110,1111,0111,0011,0001,0000 -> idx 3,4,5,6,7,0; wrap=1 only on the 0000 output.
- Illegal code: locked at idx 2, din=1010 -> err=1, err_cnt=1, locked=0, idx stays 2, idx_valid=0. Then 1000,1100,1110 -> relocks at idx 3.
- Skip: locked at 1100 (idx 2), din=1111 -> err=1, idx=4, locked=0. Then 0111,0011 -> locked=1 at idx 6.
- Ring, MODE=0, WIDTH=4:
  - 0001,1000,0100,0010,0001 -> idx 0,1,2,3,0; wrap on the final sample.
  - Then 0011 -> err=1. Then 0000 -> err=1, err_cnt=2.
- Gaps and reset:
  - Locked, din_valid=0 for 5 cycles -> all state holds, no pulses.
  - rst=0 for 1 cycle mid-locked -> all outputs 0 next cycle.
  - 300 consecutive illegal samples -> err_cnt=255.

Source files
------------

// File: rtl/special_counter_decoder.sv
// Receive-side checker for ring/Johnson counter buses: decodes each sample to a
// sequence index, tracks stepping, locks after a run of good steps, tallies errors.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | no usable reference index; next legal sample seeds one
// CONFIRM | reference held; counting consecutive correct steps
// LOCKED  | sequence tracked; a wrong step drops back to CONFIRM
module special_counter_decoder #(
    parameter int WIDTH    = 4,
    parameter int MODE     = 1,
    parameter int LOCK_CNT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din_valid,
    input  logic [WIDTH-1:0]              din,
    output logic [$clog2(2*WIDTH)-1:0]    idx,
    output logic                          idx_valid,
    output logic                          locked,
    output logic                          err,
    output logic                          wrap,
    output logic [7:0]                    err_cnt
);

    localparam int N    = (MODE == 0) ? WIDTH : 2 * WIDTH;
    localparam int IDXW = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        match_q;
    logic [IDXW-1:0]   idx_q;
    logic              idx_valid_q;
    logic              locked_q;
    logic              err_q;
    logic              wrap_q;
    logic [7:0]        err_cnt_q;

    logic              legal_d;
    logic [IDXW-1:0]   dec_idx_d;
    logic [IDXW-1:0]   step_idx_d;
    logic              step_ok_d;

    // Code word for sequence index k, built directly from the index rules so
    // legality and decode fall out of one table compare.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (MODE == 0)
                c[b] = (b == ((WIDTH - k) % WIDTH));
            else if (k <= WIDTH)
                c[b] = (b >= (WIDTH - k));
            else
                c[b] = (b < (2 * WIDTH - k));
        end
        return c;
    endfunction

    always_comb begin
        legal_d   = 1'b0;
        dec_idx_d = '0;
        for (int k = 0; k < N; k++) begin
            if (din == code_of(k)) begin
                legal_d   = 1'b1;
                dec_idx_d = IDXW'(k);
            end
        end
        step_idx_d = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + IDXW'(1);
        step_ok_d  = legal_d && (dec_idx_d == step_idx_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HUNT;
            match_q     <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            idx_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            if (din_valid) begin
                if (!legal_d) begin
                    err_q     <= 1'b1;
                    err_cnt_q <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    state_q   <= HUNT;
                    match_q   <= '0;
                    locked_q  <= 1'b0;
                end else begin
                    idx_q       <= dec_idx_d;
                    idx_valid_q <= 1'b1;
                    case (state_q)
                        HUNT: begin
                            state_q <= CONFIRM;
                            match_q <= '0;
                        end
                        CONFIRM: begin
                            if (step_ok_d) begin
                                if (match_q == 4'(LOCK_CNT - 1)) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                                match_q <= match_q + 4'd1;
                            end else begin
                                match_q <= '0;
                            end
                        end
                        LOCKED: begin
                            if (step_ok_d) begin
                                wrap_q <= (idx_q == IDXW'(N - 1));
                            end else begin
                                err_q     <= 1'b1;
                                err_cnt_q <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                                locked_q  <= 1'b0;
                                state_q   <= CONFIRM;
                                match_q   <= '0;
                            end
                        end
                        default: begin
                            state_q  <= HUNT;
                            match_q  <= '0;
                            locked_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign wrap      = wrap_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_special_counter_decoder.sv
// Bench for special_counter_decoder: a Johnson and a ring instance checked
// against directed vectors and a sequence-list reference model.
module tb_special_counter_decoder;

    logic       clk;
    logic       rst;
    logic       j_vld, r_vld;
    logic [3:0] j_din, r_din;
    logic [2:0] j_idx, r_idx;
    logic       j_iv, j_lk, j_err, j_wrap;
    logic       r_iv, r_lk, r_err, r_wrap;
    logic [7:0] j_ec, r_ec;

    special_counter_decoder #(.WIDTH(4), .MODE(1), .LOCK_CNT(2)) u_john (
        .clk(clk), .rst(rst), .din_valid(j_vld), .din(j_din),
        .idx(j_idx), .idx_valid(j_iv), .locked(j_lk), .err(j_err),
        .wrap(j_wrap), .err_cnt(j_ec)
    );

    special_counter_decoder #(.WIDTH(4), .MODE(0), .LOCK_CNT(2)) u_ring (
        .clk(clk), .rst(rst), .din_valid(r_vld), .din(r_din),
        .idx(r_idx), .idx_valid(r_iv), .locked(r_lk), .err(r_err),
        .wrap(r_wrap), .err_cnt(r_ec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Code sequences produced by stepping each generator from index 0.
    logic [3:0] seq_tab [2][8];

    // Reference model state, one slot per instance (0 = Johnson, 1 = ring).
    int m_idx [2];
    bit m_iv [2], m_lk [2], m_err [2], m_wrap [2];
    int m_ec [2];
    int m_phase [2];   // 0 searching, 1 confirming, 2 tracking
    int m_run [2];

    function automatic int seq_len(int u);
        return (u == 0) ? 8 : 4;
    endfunction

    function automatic int find_code(int u, logic [3:0] d);
        for (int k = 0; k < seq_len(u); k++)
            if (seq_tab[u][k] == d) return k;
        return -1;
    endfunction

    task automatic model_step(int u, bit r, bit v, logic [3:0] d);
        int k, prev;
        bit good;
        if (!r) begin
            m_idx[u] = 0; m_iv[u] = 0; m_lk[u] = 0; m_err[u] = 0; m_wrap[u] = 0;
            m_ec[u] = 0; m_phase[u] = 0; m_run[u] = 0;
            return;
        end
        m_iv[u] = 0; m_err[u] = 0; m_wrap[u] = 0;
        if (!v) return;
        k = find_code(u, d);
        if (k < 0) begin
            m_err[u] = 1;
            if (m_ec[u] < 255) m_ec[u]++;
            m_phase[u] = 0; m_run[u] = 0; m_lk[u] = 0;
            return;
        end
        prev = m_idx[u];
        good = (k == (prev + 1) % seq_len(u));
        m_idx[u] = k;
        m_iv[u] = 1;
        if (m_phase[u] == 0) begin
            m_phase[u] = 1; m_run[u] = 0;
        end else if (m_phase[u] == 1) begin
            if (good) begin
                m_run[u]++;
                if (m_run[u] >= 2) begin m_phase[u] = 2; m_lk[u] = 1; end
            end else m_run[u] = 0;
        end else begin
            if (good) m_wrap[u] = (prev == seq_len(u) - 1);
            else begin
                m_err[u] = 1;
                if (m_ec[u] < 255) m_ec[u]++;
                m_lk[u] = 0; m_phase[u] = 1; m_run[u] = 0;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(int u);
        string p;
        p = (u == 0) ? "john" : "ring";
        if (u == 0) begin
            chk({p, ".idx"}, 32'(j_idx), 32'(m_idx[0]));
            chk({p, ".idx_valid"}, 32'(j_iv), 32'(m_iv[0]));
            chk({p, ".locked"}, 32'(j_lk), 32'(m_lk[0]));
            chk({p, ".err"}, 32'(j_err), 32'(m_err[0]));
            chk({p, ".wrap"}, 32'(j_wrap), 32'(m_wrap[0]));
            chk({p, ".err_cnt"}, 32'(j_ec), 32'(m_ec[0]));
            chk({p, ".err_and_wrap"}, 32'(j_err & j_wrap), 32'd0);
        end else begin
            chk({p, ".idx"}, 32'(r_idx), 32'(m_idx[1]));
            chk({p, ".idx_valid"}, 32'(r_iv), 32'(m_iv[1]));
            chk({p, ".locked"}, 32'(r_lk), 32'(m_lk[1]));
            chk({p, ".err"}, 32'(r_err), 32'(m_err[1]));
            chk({p, ".wrap"}, 32'(r_wrap), 32'(m_wrap[1]));
            chk({p, ".err_cnt"}, 32'(r_ec), 32'(m_ec[1]));
            chk({p, ".err_and_wrap"}, 32'(r_err & r_wrap), 32'd0);
        end
    endtask

    task automatic cycle(bit r, bit jv, logic [3:0] jd, bit rv, logic [3:0] rd);
        rst = r; j_vld = jv; j_din = jd; r_vld = rv; r_din = rd;
        @(posedge clk);
        #1;
        model_step(0, r, jv, jd);
        model_step(1, r, rv, rd);
        check_model(0);
        check_model(1);
    endtask

    typedef struct {
        bit         sel;     // 0 = Johnson instance, 1 = ring instance
        bit         r;
        bit         v;
        logic [3:0] d;
        int         idx;
        bit         iv, lk, er, wr;
        int         ec;
    } vec_t;

    vec_t vq[$];

    task automatic add(bit sel, bit r, bit v, logic [3:0] d, int ix,
                       bit iv, bit lk, bit er, bit wr, int ec);
        vec_t t;
        t = '{sel: sel, r: r, v: v, d: d, idx: ix, iv: iv, lk: lk, er: er, wr: wr, ec: ec};
        vq.push_back(t);
    endtask

    initial begin
        logic [3:0] c;
        int gp [2];
        bit r;
        bit vv [2];
        logic [3:0] dd [2];
        int pick;

        rst = 1'b0; j_vld = 1'b0; r_vld = 1'b0; j_din = '0; r_din = '0;

        c = 4'b0000;
        for (int k = 0; k < 8; k++) begin seq_tab[0][k] = c; c = {~c[0], c[3:1]}; end
        c = 4'b0001;
        for (int k = 0; k < 8; k++) begin seq_tab[1][k] = c; c = {c[0], c[3:1]}; end

        //   sel r v din      idx iv lk er wr ec
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 4'b0000, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 4'b1000, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 4'b1100, 2, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4'b1110, 3, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4'b1111, 4, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4'b0111, 5, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4'b0011, 6, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4'b0001, 7, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4'b0000, 0, 1, 1, 0, 1, 0);
        add(0, 1, 1, 4'b1000, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4'b1100, 2, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4'b1010, 2, 0, 0, 1, 0, 1);   // illegal while locked
        add(0, 1, 1, 4'b1000, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 4'b1100, 2, 1, 0, 0, 0, 1);
        add(0, 1, 1, 4'b1110, 3, 1, 1, 0, 0, 1);
        add(0, 1, 1, 4'b1111, 4, 1, 1, 0, 0, 1);
        add(0, 1, 1, 4'b0111, 5, 1, 1, 0, 0, 1);
        add(0, 1, 1, 4'b0011, 6, 1, 1, 0, 0, 1);
        add(0, 1, 1, 4'b0001, 7, 1, 1, 0, 0, 1);
        add(0, 1, 1, 4'b0000, 0, 1, 1, 0, 1, 1);
        add(0, 1, 1, 4'b1000, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 4'b1100, 2, 1, 1, 0, 0, 1);
        add(0, 1, 1, 4'b1111, 4, 1, 0, 1, 0, 2);   // skipped code while locked
        add(0, 1, 1, 4'b0111, 5, 1, 0, 0, 0, 2);
        add(0, 1, 1, 4'b0011, 6, 1, 1, 0, 0, 2);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 4'b1010, 6, 0, 1, 0, 0, 2);  // gap, din ignored
        add(0, 0, 1, 4'b0111, 0, 0, 0, 0, 0, 0);      // reset mid-lock
        add(0, 1, 1, 4'b0001, 7, 1, 0, 0, 0, 0);
        add(1, 1, 1, 4'b0001, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 4'b1000, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 4'b0100, 2, 1, 1, 0, 0, 0);
        add(1, 1, 1, 4'b0010, 3, 1, 1, 0, 0, 0);
        add(1, 1, 1, 4'b0001, 0, 1, 1, 0, 1, 0);
        add(1, 1, 1, 4'b0011, 0, 0, 0, 1, 0, 1);
        add(1, 1, 1, 4'b0000, 0, 0, 0, 1, 0, 2);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].sel == 0) cycle(vq[i].r, vq[i].v, vq[i].d, 1'b0, 4'b0000);
            else                cycle(vq[i].r, 1'b0, 4'b0000, vq[i].v, vq[i].d);
            if (vq[i].sel == 0) begin
                chk($sformatf("vec%0d.idx", i), 32'(j_idx), 32'(vq[i].idx));
                chk($sformatf("vec%0d.idx_valid", i), 32'(j_iv), 32'(vq[i].iv));
                chk($sformatf("vec%0d.locked", i), 32'(j_lk), 32'(vq[i].lk));
                chk($sformatf("vec%0d.err", i), 32'(j_err), 32'(vq[i].er));
                chk($sformatf("vec%0d.wrap", i), 32'(j_wrap), 32'(vq[i].wr));
                chk($sformatf("vec%0d.err_cnt", i), 32'(j_ec), 32'(vq[i].ec));
            end else begin
                chk($sformatf("vec%0d.idx", i), 32'(r_idx), 32'(vq[i].idx));
                chk($sformatf("vec%0d.idx_valid", i), 32'(r_iv), 32'(vq[i].iv));
                chk($sformatf("vec%0d.locked", i), 32'(r_lk), 32'(vq[i].lk));
                chk($sformatf("vec%0d.err", i), 32'(r_err), 32'(vq[i].er));
                chk($sformatf("vec%0d.wrap", i), 32'(r_wrap), 32'(vq[i].wr));
                chk($sformatf("vec%0d.err_cnt", i), 32'(r_ec), 32'(vq[i].ec));
            end
        end

        // Long illegal burst drives both tallies into saturation.
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 4'b1010, 1'b1, 4'b0011);
        chk("sat.john_err_cnt", 32'(j_ec), 32'd255);
        chk("sat.ring_err_cnt", 32'(r_ec), 32'd255);
        chk("sat.john_err", 32'(j_err), 32'd1);
        chk("sat.ring_err", 32'(r_err), 32'd1);

        cycle(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
        gp[0] = 0; gp[1] = 0;
        for (int n = 0; n < 2500; n++) begin
            r = ($urandom_range(0, 63) != 0);
            for (int u = 0; u < 2; u++) begin
                vv[u] = ($urandom_range(0, 3) != 0);
                pick = $urandom_range(0, 9);
                if (pick <= 6) begin
                    gp[u] = (gp[u] + 1) % seq_len(u);
                    dd[u] = seq_tab[u][gp[u]];
                end else if (pick == 7) begin
                    dd[u] = seq_tab[u][gp[u]];
                end else if (pick == 8) begin
                    gp[u] = $urandom_range(0, seq_len(u) - 1);
                    dd[u] = seq_tab[u][gp[u]];
                end else begin
                    dd[u] = 4'($urandom_range(0, 15));
                end
            end
            cycle(r, vv[0], dd[0], vv[1], dd[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
